// File: rtl/adc_spi_in.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : adc_spi_in                                                       |
// | Purpose : Receive-only SPI slave for the external ADC. Resynchronises an   |
// |           asynchronous SCK/data pair into the system clock domain and      |
// |           assembles WORD_BITS-bit LSB-first frames. Each complete frame    |
// |           updates data_out0 with a one-cycle data_received strobe. A long  |
// |           gap between SCK rising edges discards a truncated frame.         |
// | Ports   : clock          in  1          system clock, rising edge          |
// |           reset          in  1          synchronous, active-low            |
// |           spi_clock_in   in  1          SPI SCK (async, idle low)          |
// |           spi_data_in    in  1          SPI data, stable on SCK rise       |
// |           data_out0      out WORD_BITS  last complete received word        |
// |           data_received  out 1          one-cycle pulse on update          |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module adc_spi_in #(
  parameter int WORD_BITS      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 spi_clock_in,
  input  logic                 spi_data_in,
  output logic [WORD_BITS-1:0] data_out0,
  output logic                 data_received
);

  localparam int CNT_W = $clog2(WORD_BITS);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state, state_next;
  logic                 sck_s1, sck_s2, sck_prev;
  logic                 dat_s1, dat_s2;
  logic [WORD_BITS-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_next;
  logic [TO_W-1:0]      timeout_cnt, timeout_next;
  logic [WORD_BITS-1:0] data_out_next;
  logic                 received_next;
  logic                 sck_rise;

  // Data travels through the same two-flop depth as SCK, so the sampled bit
  // lines up with the detected edge.
  assign sck_rise = sck_s2 & ~sck_prev;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sck_s1        <= 1'b0;
      sck_s2        <= 1'b0;
      sck_prev      <= 1'b0;
      dat_s1        <= 1'b0;
      dat_s2        <= 1'b0;
      state         <= IDLE;
      shift_reg     <= '0;
      bit_cnt       <= '0;
      timeout_cnt   <= '0;
      data_out0     <= '0;
      data_received <= 1'b0;
    end else begin
      sck_s1        <= spi_clock_in;
      sck_s2        <= sck_s1;
      sck_prev      <= sck_s2;
      dat_s1        <= spi_data_in;
      dat_s2        <= dat_s1;
      state         <= state_next;
      shift_reg     <= shift_next;
      bit_cnt       <= bit_cnt_next;
      timeout_cnt   <= timeout_next;
      data_out0     <= data_out_next;
      data_received <= received_next;
    end
  end

  always_comb begin
    state_next    = state;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt;
    timeout_next  = timeout_cnt;
    data_out_next = data_out0;
    received_next = 1'b0;

    unique case (state)
      IDLE: begin
        timeout_next = '0;
        if (sck_rise) begin
          shift_next    = '0;
          shift_next[0] = dat_s2;
          bit_cnt_next  = CNT_W'(1);
          state_next    = SHIFT;
        end
      end

      SHIFT: begin
        // An edge always takes priority over the timeout, so a frame whose
        // last edge lands on the expiry cycle still completes.
        if (sck_rise) begin
          shift_next[bit_cnt] = dat_s2;
          timeout_next        = '0;
          if (bit_cnt == CNT_W'(WORD_BITS - 1)) begin
            bit_cnt_next = '0;
            state_next   = DONE;
          end else begin
            bit_cnt_next = bit_cnt + CNT_W'(1);
          end
        end else if (timeout_cnt >= TO_W'(TIMEOUT_CYCLES - 1)) begin
          shift_next   = '0;
          bit_cnt_next = '0;
          timeout_next = '0;
          state_next   = IDLE;
        end else begin
          timeout_next = timeout_cnt + TO_W'(1);
        end
      end

      DONE: begin
        data_out_next = shift_reg;
        received_next = 1'b1;
        timeout_next  = '0;
        state_next    = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_in.sv
`timescale 1ns/100ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_adc_spi_in                                                    |
// | Purpose : Scoreboard bench for adc_spi_in. Stimulus pushes the word each   |
// |           complete frame should deliver; a monitor pops on every strobe.   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_adc_spi_in;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        spi_clock_in = 1'b0;
  logic        spi_data_in = 1'b0;
  logic [15:0] data_out0;
  logic        data_received;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          last_rise = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_word = 16'h0000;

  adc_spi_in #(.WORD_BITS(16), .TIMEOUT_CYCLES(1024)) dut (
    .clock         (clock),
    .reset         (reset),
    .spi_clock_in  (spi_clock_in),
    .spi_data_in   (spi_data_in),
    .data_out0     (data_out0),
    .data_received (data_received)
  );

  always #4 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest outstanding frame and arrive
  // 3-5 system cycles after the last SCK rising edge at the pin.
  always @(negedge clock) begin
    if (data_received === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe data_out0=%h required=no strobe", data_out0);
      end else begin
        logic [15:0] w;
        w = exp_q.pop_front();
        if (data_out0 !== w) begin
          miscompares++;
          $display("FAIL strobe_word data_out0=%h required=%h", data_out0, w);
        end
      end
      vectors++;
      if ((cyc - last_rise) < 3 || (cyc - last_rise) > 5) begin
        miscompares++;
        $display("FAIL strobe_latency cycles=%0d required=3..5", cyc - last_rise);
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drives n bits LSB first; data changes with SCK low, optional stall
  // before the rising edge of bit stall_at.
  task automatic send_bits(input logic [15:0] w, input int n, input int half_ns,
                           input int stall_at, input int stall_ns);
    for (int i = 0; i < n; i++) begin
      spi_clock_in = 1'b0;
      spi_data_in  = w[i];
      #(half_ns);
      if (i == stall_at) #(stall_ns);
      spi_clock_in = 1'b1;
      last_rise    = cyc;
      #(half_ns);
    end
    spi_clock_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clock);
      n++;
    end
    @(negedge clock);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL strobe_missing outstanding=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic send_frame(input logic [15:0] w, input int half_ns,
                            input int stall_at, input int stall_ns);
    exp_q.push_back(w);
    model_word = w;
    send_bits(w, 16, half_ns, stall_at, stall_ns);
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_data_out0", data_out0, 16'h0000);
    check("reset_strobe", {15'd0, data_received}, 16'h0000);
    reset = 1'b1;
    repeat (5) @(posedge clock);

    // Single frame
    send_frame(16'hAACC, 375, -1, 0);
    check("frame_aacc", data_out0, model_word);

    // Truncated frame, idle past timeout, then realigned frame
    send_bits(16'h96AA, 15, 375, -1, 0);
    #10_000;
    check("after_partial_hold", data_out0, model_word);
    send_frame(16'hAACC, 375, -1, 0);
    check("realign_aacc", data_out0, 16'hAACC);

    // Back-to-back frames with a long gap
    send_frame(16'hAACC, 375, -1, 0);
    #100_000;
    send_frame(16'h1655, 375, -1, 0);
    check("b2b_last", data_out0, 16'h1655);

    // Reset in the middle of a frame
    send_bits(16'hF0F0, 8, 375, -1, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_word = 16'h0000;
    check("midframe_reset_out", data_out0, 16'h0000);
    send_frame(16'h1655, 375, -1, 0);
    check("after_reset_frame", data_out0, 16'h1655);

    // Data activity with SCK held low, then held high
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1 spi_data_in = ~spi_data_in;
    end
    spi_clock_in = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1 spi_data_in = ~spi_data_in;
    end
    spi_clock_in = 1'b0;
    #10_000;
    check("static_sck_hold", data_out0, model_word);

    // Frame stalled just under the timeout must still complete
    send_frame(16'h5A3C, 200, 9, 7_000);
    check("stall_frame", data_out0, 16'h5A3C);

    // Randomised mix of full, truncated and stalled frames
    for (int k = 0; k < 16; k++) begin
      logic [15:0] w;
      int          kind;
      int          half;
      w    = 16'($urandom);
      kind = $urandom_range(0, 3);
      half = $urandom_range(40, 320);
      if (kind <= 1) begin
        send_frame(w, half, -1, 0);
      end else if (kind == 2) begin
        send_bits(w, $urandom_range(1, 15), half, -1, 0);
        #10_000;
      end else begin
        send_frame(w, half, $urandom_range(1, 15), $urandom_range(4_000, 7_000));
      end
      check("random_hold", data_out0, model_word);
    end

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
